// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port on-chip RAM with a fixed one-cycle read return.
// Optional fixed port-0 priority with port-1 starvation guard: define ONCHIP_MEM_ARB_PRIO0_EN.
module onchip_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 3125,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   p0_address,
    input  logic                p0_read,
    output logic                p0_waitrequest,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic                p0_readdatavalid,
    input  logic [ADDR_W-1:0]   p1_address,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W-1:0]   p1_writedata,
    output logic                p1_waitrequest,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic                p1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic              req0, req1, gnt0, gnt1;
    logic              p1_is_rd, rd_gnt, in_range;
    logic [ADDR_W-1:0] gnt_addr;
    logic              rv0_q, rv0_d, rv1_q, rv1_d, oor_q, oor_d;

    assign req0     = p0_read;
    assign req1     = p1_read | p1_write;
    assign p1_is_rd = p1_read & ~p1_write;

`ifdef ONCHIP_MEM_ARB_PRIO0_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starved;

    assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1));

    always_comb begin
        gnt1         = ~reset & req1 & (~req0 | starved);
        gnt0         = ~reset & req0 & ~gnt1;
        starve_cnt_d = '0;
        if (req1 && !gnt1) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic last_gnt_q, last_gnt_d;
    logic unused_cfg;

    assign unused_cfg = (STARVE_LIMIT == 0);

    // Under contention the port that did not win last time takes the slot.
    always_comb begin
        gnt0       = ~reset & req0 & (~req1 | last_gnt_q);
        gnt1       = ~reset & req1 & (~req0 | ~last_gnt_q);
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    assign gnt_addr       = gnt0 ? p0_address : p1_address;
    assign in_range       = {1'b0, gnt_addr} < DEPTH_W;
    assign rd_gnt         = gnt0 | (gnt1 & p1_is_rd);
    assign p0_waitrequest = req0 & ~gnt0;
    assign p1_waitrequest = req1 & ~gnt1;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (gnt0 || gnt1) begin
            mem_address    = gnt_addr;
            mem_byteenable = gnt0 ? '1 : p1_byteenable;
            mem_chipselect = in_range;
            mem_write      = gnt1 & p1_write & in_range;
            mem_writedata  = p1_writedata;
        end
    end

    // Out-of-range reads are still acknowledged; the flag zeroes their returned data.
    assign rv0_d = gnt0;
    assign rv1_d = gnt1 & p1_is_rd;
    assign oor_d = rd_gnt & ~in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
            oor_q <= 1'b0;
        end else begin
            rv0_q <= rv0_d;
            rv1_q <= rv1_d;
            oor_q <= oor_d;
        end
    end

    assign p0_readdatavalid = rv0_q;
    assign p1_readdatavalid = rv1_q;
    assign p0_readdata      = (rv0_q && !oor_q) ? mem_readdata : '0;
    assign p1_readdata      = (rv1_q && !oor_q) ? mem_readdata : '0;

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares one single-port 32-bit on-chip RAM between two Avalon-MM-style requesters.
  - Port 0: video pixel fetch.
  - Port 1: CPU data master.
- Issues at most one access per cycle and applies round-robin arbitration.
- Routes the RAM's one-cycle read data back with a per-port valid strobe.
- Blocks out-of-range addresses.
- Sits between the interconnect and the RAM slave (address/byteenable/chipselect/write/writedata/readdata).

Parameters:
- ADDR_W, 12, word address width of the RAM and of both ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 3125, number of implemented words; addresses >= DEPTH are out of range.
- STARVE_LIMIT, 8, consecutive port-1 denials before a forced grant (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p0_address  in  ADDR_W  port 0 word address
- p0_read  in  1  port 0 read request
- p0_waitrequest  out  1  port 0 stall; request not accepted this cycle
- p0_readdata  out  DATA_W  port 0 read data
- p0_readdatavalid  out  1  port 0 read data valid
- p1_address  in  ADDR_W  port 1 word address
- p1_byteenable  in  DATA_W/8  port 1 byte lanes
- p1_read  in  1  port 1 read request
- p1_write  in  1  port 1 write request
- p1_writedata  in  DATA_W  port 1 write data
- p1_waitrequest  out  1  port 1 stall
- p1_readdata  out  DATA_W  port 1 read data
- p1_readdatavalid  out  1  port 1 read data valid
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM; all ones for port 0
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_readdata  in  DATA_W  from RAM; valid one cycle after address

Behaviour:
- Request definitions: req0 = p0_read; req1 = p1_read | p1_write. If p1_read and p1_write are both set, the request is a write.
- Grant is combinational from req0, req1 and register last_gnt.
  - One requester: it wins.
  - Both requesting: the port not equal to last_gnt wins.
  - last_gnt updates on every granted cycle.
  - Reset value of last_gnt = 1, so port 0 wins the first contention.
- waitrequest: pN_waitrequest = reqN & ~gntN (combinational). It is 0 when the port is idle.
- RAM interface mux (combinational):
  - mem_address from the granted port.
  - mem_write = gnt1 & p1_write & in_range.
  - mem_chipselect = (gnt0 | gnt1) & in_range.
  - mem_writedata = p1_writedata.
  - When nothing is granted, all mem_* outputs are 0.
- Range check: in_range = granted address < DEPTH.
  - Out-of-range write: accepted (waitrequest 0), RAM untouched.
  - Out-of-range read: accepted, returns 0 with valid.
- Read return (fixed latency 1):
  - Registered rv0/rv1 set when a read is granted on that port; registered oor flag records an out-of-range read.
  - Next cycle: pN_readdatavalid = rvN, pN_readdata = oor ? 0 : mem_readdata.
  - pN_readdata = 0 when pN_readdatavalid = 0.
- Throughput: back-to-back grants every cycle; alternating grants under continuous contention (50/50).
- Reset:
  - All registers clear (rv0, rv1, oor = 0; last_gnt = 1).
  - A read granted in the cycle reset is asserted produces no valid.
  - While reset is high, grants are suppressed: waitrequest = req, mem_chipselect = 0.
- Writes produce no readdatavalid.

Optional Feature:
- Macro: ONCHIP_MEM_ARB_PRIO0_EN.
- Defined:
  - Port 0 has fixed priority over port 1.
  - Counter starve_cnt increments each cycle port 1 is denied while requesting. It clears when port 1 is granted or not requesting, and on reset.
  - When starve_cnt == STARVE_LIMIT-1, port 1 is granted next contention regardless of port 0.
  - last_gnt is unused.
- Undefined: pure round-robin as above; no counter logic.

Test Plan:
- Reset, then p1 write addr 0x010 data 0xDEADBEEF be 4'hF, then p0 read 0x010 -> p0_readdatavalid one cycle after grant, p0_readdata 0xDEADBEEF, p1_readdatavalid 0.
- p1 write 0x020 data 0x11223344 be 4'b0101 over prior 0xFFFFFFFF, then p1 read 0x020 -> 0xFF22FF44.
- Both ports read continuously for 10 cycles -> grants alternate 0,1,0,1...; 5 valids per port; waitrequest high on loser every cycle.
- p1 write 0xC40 (3136 >= DEPTH) data 0x5 -> mem_chipselect 0, no RAM change; p0 read 0xC40 -> valid with readdata 0.
- p0 read granted, reset asserted the same cycle -> no readdatavalid next cycle; first post-reset contention grants port 0.
- With ONCHIP_MEM_ARB_PRIO0_EN, both ports continuously requesting -> port 0 wins 7 cycles, port 1 granted on 8th, repeating.
